// File: rtl/bc_mac_seq_pkg.sv
// Shared types and default sizing for the bit-serial MAC sequencer.
package bc_mac_seq_pkg;
  localparam int DEF_N     = 6;
  localparam int DEF_DW    = 8;
  localparam int DEF_ACC_W = 24;
  // Column sum must hold N full-scale activations.
  localparam int DEF_CW    = DEF_DW + $clog2(DEF_N);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
endpackage

// File: rtl/bc_mac_seq_col_sum.sv
// N-input column reducer: per-lane weight-bit gating, 3:2 carry-save chain, final adder.
module mac_csa #(
  parameter int W = 11
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] co
);
  logic [W-1:0] maj;
  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  // Top carry bit is dropped: the true column sum always fits in W.
  assign co  = maj << 1;
endmodule

module mac_col_sum #(
  parameter int N  = 6,
  parameter int DW = 8,
  parameter int CW = 11
) (
  input  logic [N-1:0][DW-1:0] act,
  input  logic [N-1:0]         wbit,
  output logic [CW-1:0]        colsum
);
  logic [N-1:0][CW-1:0] col, s, c;

  for (genvar i = 0; i < N; i++) begin : g_gate
    assign col[i] = wbit[i] ? CW'(act[i]) : '0;
  end

  assign s[0] = col[0];
  assign c[0] = '0;
  for (genvar i = 1; i < N; i++) begin : g_csa
    mac_csa #(.W(CW)) u_csa (
      .a (s[i-1]),
      .b (c[i-1]),
      .c (col[i]),
      .s (s[i]),
      .co(c[i])
    );
  end

  assign colsum = s[N-1] + c[N-1];
endmodule

// File: rtl/bc_mac_seq.sv
// Bit-serial MAC sequencer: walks weight bits LSB-first, shift-adding column sums.
// Define BC_MAC_SIGNED_EN for two's-complement weights (MSB column subtracts).
module bc_mac_seq
  import bc_mac_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   in_act,
  input  logic [N*DW-1:0]   in_wgt,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              busy
);
  localparam int CW = DW + $clog2(N);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
`ifdef BC_MAC_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  state_t               state;
  logic [BW-1:0]        b;
  logic [N-1:0][DW-1:0] act_q, wgt_q;
  logic                 last_q;
  logic [ACC_W-1:0]     acc;
  logic [N-1:0]         wbit;
  logic [CW-1:0]        colsum;
  logic [ACC_W-1:0]     term;
  logic                 b_top;

  always_comb begin
    wbit = '0;
    for (int i = 0; i < N; i++) wbit[i] = wgt_q[i][b];
  end

  mac_col_sum #(.N(N), .DW(DW), .CW(CW)) u_col (
    .act   (act_q),
    .wbit  (wbit),
    .colsum(colsum)
  );

  assign b_top = (b == BW'(DW - 1));
  assign term  = ACC_W'(colsum) << b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      b      <= '0;
      act_q  <= '0;
      wgt_q  <= '0;
      last_q <= 1'b0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          act_q  <= in_act;
          wgt_q  <= in_wgt;
          last_q <= in_last;
          b      <= '0;
          state  <= RUN;
        end
        RUN: begin
          acc <= (SGN && b_top) ? acc - term : acc + term;
          if (b_top) begin
            b     <= '0;
            state <= last_q ? OUT : IDLE;
          end else begin
            b <= b + 1'b1;
          end
        end
        OUT: if (out_ready) begin
          acc   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;
endmodule

// File: tb/tb_bc_mac_seq.sv
// Directed bench for bc_mac_seq (N=6, DW=8, ACC_W=24); follows BC_MAC_SIGNED_EN.
module tb_bc_mac_seq;
  localparam int N = 6, DW = 8, ACC_W = 24;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [N-1:0][DW-1:0] in_act = '0, in_wgt = '0;
  logic in_ready, out_valid, busy;
  logic [ACC_W-1:0] out_acc;

  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  bc_mac_seq #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .busy(busy)
  );

  typedef struct packed {
    logic [N-1:0][DW-1:0] act;
    logic [N-1:0][DW-1:0] wgt;
    logic [ACC_W-1:0]     exp_u;
    logic [ACC_W-1:0]     exp_s;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  function automatic logic [ACC_W-1:0] pick(input vec_t v);
`ifdef BC_MAC_SIGNED_EN
    return v.exp_s;
`else
    return v.exp_u;
`endif
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".busy"}, 64'(busy), 64'd0);
    chk({nm, ".out_acc"}, 64'(out_acc), 64'd0);
  endtask

  // Handshake one vector, scramble the inputs, then count cycles until the
  // block returns (out_valid for last, in_ready otherwise); in_ready must stay low while running.
  task automatic send(input logic [N-1:0][DW-1:0] a, input logic [N-1:0][DW-1:0] w,
                      input logic last, output int lat);
    int t;
    bit rdy_leak;
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (!in_ready) chk("send.wait_ready", 64'(in_ready), 64'd1);
    in_act = a; in_wgt = w; in_last = last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_act = {$urandom, $urandom};
    in_wgt = {$urandom, $urandom};
    in_last = ~last;
    lat = 0;
    rdy_leak = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (last ? out_valid : in_ready) begin lat = c; break; end
      if (in_ready || out_valid || !busy) rdy_leak = 1'b1;
    end
    chk("send.run_window", 64'(rdy_leak), 64'd0);
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk_idle("after_consume");
  endtask

  vec_t vt[5];
  int lat;

  initial begin
    vt[0] = '{act: {N{8'd1}}, wgt: {N{8'd1}}, exp_u: 24'd6, exp_s: 24'd6};
    vt[1] = '{act: {N{8'd255}}, wgt: {N{8'd255}}, exp_u: 24'd390150, exp_s: 24'hFFFA06};
    vt[2] = '{act: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3},
              wgt: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF}, exp_u: 24'd765, exp_s: 24'hFFFFFD};
    vt[3] = '{act: {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10},
              wgt: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, exp_u: 24'd910, exp_s: 24'd910};
    vt[4] = '{act: {8'd0, 8'd0, 8'h80, 8'd0, 8'd0, 8'd0},
              wgt: {8'd0, 8'd0, 8'h7F, 8'd0, 8'd0, 8'd0}, exp_u: 24'd16256, exp_s: 24'd16256};

    #12;
    chk_idle("reset");
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    foreach (vt[i]) begin
      send(vt[i].act, vt[i].wgt, 1'b1, lat);
      chk($sformatf("vec%0d.latency", i), 64'(lat), 64'd9);
      chk($sformatf("vec%0d.out_acc", i), 64'(out_acc), 64'(pick(vt[i])));
      consume();
    end

    // Accumulation across a non-last vector.
    send({N{8'd2}}, {N{8'd3}}, 1'b0, lat);
    chk("two.first_ready_latency", 64'(lat), 64'd9);
    chk("two.first_no_valid", 64'(out_valid), 64'd0);
    send({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, 1'b1, lat);
    chk("two.latency", 64'(lat), 64'd9);
    chk("two.out_acc", 64'(out_acc), 64'd37);
    consume();

    // Result held under back-pressure.
    send({N{8'd1}}, {N{8'd1}}, 1'b1, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d.out_acc", c), 64'(out_acc), 64'd6);
      chk($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'd0);
    end
    consume();

    // Reset mid-RUN at bit 4, then a clean vector.
    in_act = {N{8'd200}}; in_wgt = {N{8'd255}}; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrun_reset");
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("midrun_release");
    send({N{8'd1}}, {N{8'd1}}, 1'b1, lat);
    chk("after_reset.latency", 64'(lat), 64'd9);
    chk("after_reset.out_acc", 64'(out_acc), 64'd6);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
